// File: rtl/hazard_forward_ctrl.sv
// Hazard/forwarding controller: a shift-register scoreboard of in-flight
// destinations drives EX forward selects, load-use stalls and branch flushes.

module hazard_forward_ctrl_src #(
  parameter int REG_AW     = 5,
  parameter int NSTAGE     = 3,
  parameter int LOAD_READY = 2
) (
  input  logic [NSTAGE-1:0]             wr_i,
  input  logic [NSTAGE-1:0]             ld_i,
  input  logic [NSTAGE-1:0][REG_AW-1:0] rd_i,
  input  logic [REG_AW-1:0]             rs_i,
  input  logic                          use_i,
  output logic                          hz_o,
  output logic [$clog2(NSTAGE)-1:0]     fwd_o
);
  localparam int FW = $clog2(NSTAGE);

  logic hit;

  // Scan youngest first so the nearest producer wins; the last entry only
  // relies on regfile write-through and never forwards.
  always_comb begin
    hz_o  = 1'b0;
    fwd_o = '0;
    hit   = 1'b0;
    for (int k = 0; k < NSTAGE; k++) begin
      if (!hit && use_i && wr_i[k] && rd_i[k] == rs_i && rs_i != '0) begin
        hit  = 1'b1;
        hz_o = ld_i[k] && (k + 1 < LOAD_READY);
        if (k + 1 <= NSTAGE - 1) fwd_o = FW'(k + 1);
      end
    end
  end
endmodule

module hazard_forward_ctrl #(
  parameter int REG_AW      = 5,
  parameter int NSTAGE      = 3,
  parameter int LOAD_READY  = 2,
  parameter int FLUSH_DEPTH = 1,
  parameter int CNT_W       = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      id_valid,
  input  logic [REG_AW-1:0]         id_rs1,
  input  logic [REG_AW-1:0]         id_rs2,
  input  logic                      id_use_rs1,
  input  logic                      id_use_rs2,
  input  logic [REG_AW-1:0]         id_rd,
  input  logic                      id_regwrite,
  input  logic                      id_memread,
  input  logic                      flush_i,
  output logic                      stall_o,
  output logic                      ifid_flush_o,
  output logic                      idex_flush_o,
  output logic [$clog2(NSTAGE)-1:0] fwd_a,
  output logic [$clog2(NSTAGE)-1:0] fwd_b,
  output logic [CNT_W-1:0]          stall_cnt,
  output logic [CNT_W-1:0]          flush_cnt
);
  localparam int FW = $clog2(NSTAGE);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              regwrite;
    logic              is_load;
  } ent_t;

  ent_t [NSTAGE-1:0]             sb_q, sb_d;
  logic [NSTAGE-1:0]             ent_wr, ent_ld;
  logic [NSTAGE-1:0][REG_AW-1:0] ent_rd;
  logic [1:0][REG_AW-1:0]        src_rs;
  logic [1:0]                    src_use, src_hz;
  logic [1:0][FW-1:0]            fwd_n, fwd_d, fwd_q;
  logic                          issue;
  logic [CNT_W-1:0]              stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  for (genvar k = 0; k < NSTAGE; k++) begin : g_ent
    assign ent_wr[k] = sb_q[k].valid & sb_q[k].regwrite;
    assign ent_ld[k] = sb_q[k].is_load;
    assign ent_rd[k] = sb_q[k].rd;
  end

  assign src_rs  = {id_rs2, id_rs1};
  assign src_use = {id_use_rs2, id_use_rs1};

  for (genvar g = 0; g < 2; g++) begin : g_src
    hazard_forward_ctrl_src #(
      .REG_AW    (REG_AW),
      .NSTAGE    (NSTAGE),
      .LOAD_READY(LOAD_READY)
    ) u_src (
      .wr_i (ent_wr),
      .ld_i (ent_ld),
      .rd_i (ent_rd),
      .rs_i (src_rs[g]),
      .use_i(src_use[g]),
      .hz_o (src_hz[g]),
      .fwd_o(fwd_n[g])
    );
  end

  assign stall_o      = id_valid & ~flush_i & (|src_hz);
  assign ifid_flush_o = flush_i;
  assign idex_flush_o = flush_i;
  assign issue        = id_valid & ~stall_o & ~flush_i;

  always_comb begin
    sb_d             = '0;
    sb_d[0].valid    = issue;
    sb_d[0].rd       = id_rd;
    sb_d[0].regwrite = id_regwrite;
    sb_d[0].is_load  = id_memread;
    for (int k = 1; k < NSTAGE; k++) begin
      sb_d[k] = sb_q[k-1];
      // Flush kills the wrong-path instructions younger than the branch.
      if (flush_i && k <= FLUSH_DEPTH) sb_d[k].valid = 1'b0;
    end
    fwd_d       = issue ? fwd_n : '0;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_o && stall_cnt_q != {CNT_W{1'b1}}) stall_cnt_d = stall_cnt_q + 1'b1;
    if (flush_i && flush_cnt_q != {CNT_W{1'b1}}) flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sb_q        <= '0;
      fwd_q       <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      sb_q        <= sb_d;
      fwd_q       <= fwd_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign fwd_a     = fwd_q[0];
  assign fwd_b     = fwd_q[1];
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
endmodule
